// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_ctrl
// Brief    : Debounced button levels -> PRESS/RELEASE/LONG/REPEAT event queue
//            with per-button pending slots, round-robin arbiter and event FIFO.
// Revision : 1.0  initial release
// ============================================================================
module btn_event_ctrl #(
    parameter int WIDTH        = 5,
    parameter int IDX_WIDTH    = 3,
    parameter int LONG_TICKS   = 50000000,
    parameter int REPEAT_TICKS = 10000000,
    parameter int CNT_WIDTH    = 26,
    parameter int FIFO_DEPTH   = 4,
    parameter int PTR_WIDTH    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     btn_level,
    input  logic                 repeat_en,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [IDX_WIDTH-1:0] evt_btn,
    output logic [1:0]           evt_type,
    output logic [WIDTH-1:0]     btn_busy,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam logic [1:0]           c_evt_press   = 2'b00;
    localparam logic [1:0]           c_evt_release = 2'b01;
    localparam logic [1:0]           c_evt_long    = 2'b10;
    localparam logic [1:0]           c_evt_repeat  = 2'b11;
    localparam logic [CNT_WIDTH-1:0] c_long_last   = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] c_rep_last    = CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [IDX_WIDTH-1:0] c_last_idx    = IDX_WIDTH'(WIDTH - 1);
    localparam logic [IDX_WIDTH:0]   c_width_ext   = (IDX_WIDTH + 1)'(WIDTH);
    localparam logic [PTR_WIDTH:0]   c_depth       = (PTR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_btn_q;
    logic [WIDTH-1:0] r_btn_prev;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_q    <= '0;
            r_btn_prev <= '0;
        end else begin
            r_btn_q    <= btn_level;
            r_btn_prev <= r_btn_q;
        end
    end

    assign w_rise = r_btn_q & ~r_btn_prev;
    assign w_fall = ~r_btn_q & r_btn_prev;

    // ------------------------------------------------------------------
    // Per-button FSMs; emitted events are registered before the slot stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_emit_valid;
    logic [1:0]       w_emit_type [WIDTH];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_btn
        state_t               r_state;
        state_t               w_state_nxt;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] w_cnt_nxt;
        logic                 w_emit;
        logic [1:0]           w_type;
        logic                 r_emit;
        logic [1:0]           r_type;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_emit      = 1'b0;
            w_type      = c_evt_press;
            case (r_state)
                S_IDLE: begin
                    if (w_rise[gi]) begin
                        w_emit      = 1'b1;
                        w_type      = c_evt_press;
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PRESSED: begin
                    if (w_fall[gi]) begin
                        w_emit      = 1'b1;
                        w_type      = c_evt_release;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_long_last) begin
                        w_emit      = 1'b1;
                        w_type      = c_evt_long;
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (w_fall[gi]) begin
                        w_emit      = 1'b1;
                        w_type      = c_evt_release;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (!repeat_en) begin
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_rep_last) begin
                        w_emit      = 1'b1;
                        w_type      = c_evt_repeat;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_emit  <= 1'b0;
                r_type  <= c_evt_press;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_emit  <= w_emit;
                r_type  <= w_type;
            end
        end

        assign w_emit_valid[gi] = r_emit;
        assign w_emit_type[gi]  = r_type;
        assign btn_busy[gi]     = (r_state != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Pending slots and round-robin arbiter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     r_slot_valid;
    logic [1:0]           r_slot_type [WIDTH];
    logic [IDX_WIDTH-1:0] r_rr_ptr;
    logic                 w_fifo_full;
    logic                 w_gnt_valid;
    logic [IDX_WIDTH-1:0] w_gnt_idx;
    logic [1:0]           w_gnt_type;
    logic [WIDTH-1:0]     w_gnt_vec;
    logic [IDX_WIDTH:0]   w_dist;
    logic [IDX_WIDTH:0]   w_best;
    logic                 w_drop;

    // r_rr_ptr holds the next search start (last grant + 1); reset starts at 0
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_type  = c_evt_press;
        w_dist      = '0;
        w_best      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (IDX_WIDTH'(i) >= r_rr_ptr) begin
                w_dist = {1'b0, IDX_WIDTH'(i) - r_rr_ptr};
            end else begin
                w_dist = {1'b0, IDX_WIDTH'(i)} + c_width_ext - {1'b0, r_rr_ptr};
            end
            if (r_slot_valid[i] && !w_fifo_full && (!w_gnt_valid || (w_dist < w_best))) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = IDX_WIDTH'(i);
                w_gnt_type  = r_slot_type[i];
                w_best      = w_dist;
            end
        end
    end

    assign w_gnt_vec = w_gnt_valid ? (WIDTH'(1) << w_gnt_idx) : '0;
    assign w_drop    = |(w_emit_valid & r_slot_valid & ~w_gnt_vec);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_valid <= '0;
            r_rr_ptr     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_slot_type[i] <= c_evt_press;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_emit_valid[i]) begin
                    if (!r_slot_valid[i] || w_gnt_vec[i]) begin
                        r_slot_valid[i] <= 1'b1;
                        r_slot_type[i]  <= w_emit_type[i];
                    end
                end else if (w_gnt_vec[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
            if (w_gnt_valid) begin
                r_rr_ptr <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO; full is judged on the registered count only
    // ------------------------------------------------------------------
    logic [IDX_WIDTH+1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [PTR_WIDTH:0]   r_count;
    logic                 w_pop;

    assign w_fifo_full = (r_count == c_depth);
    assign evt_valid   = (r_count != '0);
    assign w_pop       = evt_valid & evt_ready;
    assign {evt_btn, evt_type} = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_gnt_valid) begin
                r_mem[r_wr_ptr] <= {w_gnt_idx, w_gnt_type};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_gnt_valid, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_ctrl
// Brief    : Directed self-checking bench for btn_event_ctrl (short tick counts).
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_event_ctrl;

    localparam int WIDTH        = 5;
    localparam int IDX_WIDTH    = 3;
    localparam int LONG_TICKS   = 8;
    localparam int REPEAT_TICKS = 4;
    localparam int CNT_WIDTH    = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int PTR_WIDTH    = 2;

    localparam int c_press   = 0;
    localparam int c_release = 1;
    localparam int c_long    = 2;
    localparam int c_repeat  = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [WIDTH-1:0]     btn_level;
    logic                 repeat_en;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [IDX_WIDTH-1:0] evt_btn;
    logic [1:0]           evt_type;
    logic [WIDTH-1:0]     btn_busy;
    logic                 overflow;
    logic                 overflow_clr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int q_btn [$];
    int q_type [$];
    int q_cyc [$];

    btn_event_ctrl #(
        .WIDTH        (WIDTH),
        .IDX_WIDTH    (IDX_WIDTH),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS),
        .CNT_WIDTH    (CNT_WIDTH),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PTR_WIDTH    (PTR_WIDTH)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_level    (btn_level),
        .repeat_en    (repeat_en),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_type     (evt_type),
        .btn_busy     (btn_busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted events are logged on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            q_btn.push_back(int'(evt_btn));
            q_type.push_back(int'(evt_type));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        q_btn.delete();
        q_type.delete();
        q_cyc.delete();
    endtask

    task automatic check_evt(input string tag, input int i, input int b, input int t);
        check_value({tag, "_btn"},  (i < q_btn.size())  ? q_btn[i]  : -1, b);
        check_value({tag, "_type"}, (i < q_type.size()) ? q_type[i] : -1, t);
    endtask

    function automatic int gap(input int i);
        return (i < q_cyc.size()) ? (q_cyc[i] - q_cyc[0]) : -1;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        clear_log();
    endtask

    initial begin
        reset_n      = 1'b0;
        btn_level    = '0;
        repeat_en    = 1'b0;
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;
        tick(2);

        check_value("rst_valid",    evt_valid, 0);
        check_value("rst_btn",      evt_btn,   0);
        check_value("rst_type",     evt_type,  0);
        check_value("rst_busy",     btn_busy,  0);
        check_value("rst_overflow", overflow,  0);
        reset_n = 1'b1;
        tick(1);

        // 1: short press on btn0, latency of first event
        btn_level[0] = 1'b1;
        tick(2);
        check_value("t1_busy", btn_busy[0], 1);
        tick(1);
        check_value("t1_lat_early", evt_valid, 0);
        btn_level[0] = 1'b0;
        tick(1);
        check_value("t1_lat_valid", evt_valid, 1);
        check_value("t1_lat_btn",   evt_btn,   0);
        check_value("t1_lat_type",  evt_type,  c_press);
        tick(12);
        check_value("t1_count", q_btn.size(), 2);
        check_evt("t1_e0", 0, 0, c_press);
        check_evt("t1_e1", 1, 0, c_release);
        check_value("t1_idle", btn_busy, 0);

        // 2: long hold with repeats; release coincides with a repeat boundary
        clear_log();
        repeat_en    = 1'b1;
        btn_level[2] = 1'b1;
        tick(20);
        check_value("t2_busy", btn_busy[2], 1);
        btn_level[2] = 1'b0;
        tick(12);
        check_value("t2_count", q_btn.size(), 5);
        check_evt("t2_e0", 0, 2, c_press);
        check_evt("t2_e1", 1, 2, c_long);
        check_evt("t2_e2", 2, 2, c_repeat);
        check_evt("t2_e3", 3, 2, c_repeat);
        check_evt("t2_e4", 4, 2, c_release);
        check_value("t2_gap_long", gap(1), 8);
        check_value("t2_gap_rep0", gap(2), 12);
        check_value("t2_gap_rep1", gap(3), 16);
        check_value("t2_gap_rel",  gap(4), 20);
        repeat_en = 1'b0;

        // 3: simultaneous presses, round-robin order from a fresh pointer
        do_reset();
        btn_level = 5'b01011;
        tick(4);
        btn_level = '0;
        tick(12);
        check_value("t3_count", q_btn.size(), 6);
        check_evt("t3_e0", 0, 0, c_press);
        check_evt("t3_e1", 1, 1, c_press);
        check_evt("t3_e2", 2, 3, c_press);
        check_evt("t3_e3", 3, 0, c_release);
        check_evt("t3_e4", 4, 1, c_release);
        check_evt("t3_e5", 5, 3, c_release);
        check_value("t3_gap1", gap(1), 1);
        check_value("t3_gap2", gap(2), 2);

        // 4: stalled consumer, fill FIFO, one pending, one dropped
        evt_ready = 1'b0;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            btn_level[4] = 1'b1;
            tick(3);
            btn_level[4] = 1'b0;
            tick(3);
        end
        check_value("t4_full_valid", evt_valid, 1);
        check_value("t4_head_btn",   evt_btn,   4);
        check_value("t4_head_type",  evt_type,  c_press);
        check_value("t4_no_ovf",     overflow,  0);
        btn_level[4] = 1'b1;
        tick(3);
        btn_level[4] = 1'b0;
        tick(4);
        check_value("t4_ovf_set",     overflow,    1);
        check_value("t4_busy",        btn_busy[4], 0);
        check_value("t4_stable_btn",  evt_btn,     4);
        check_value("t4_stable_type", evt_type,    c_press);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check_value("t4_ovf_clr", overflow, 0);
        evt_ready = 1'b1;
        tick(12);
        check_value("t4_count", q_btn.size(), 5);
        check_evt("t4_e0", 0, 4, c_press);
        check_evt("t4_e1", 1, 4, c_release);
        check_evt("t4_e2", 2, 4, c_press);
        check_evt("t4_e3", 3, 4, c_release);
        check_evt("t4_e4", 4, 4, c_press);
        check_value("t4_drained", evt_valid, 0);
        check_value("t4_ovf_stay", overflow, 0);

        // 5: asynchronous reset while btn1 is HELD with FIFO content
        evt_ready = 1'b0;
        do_reset();
        btn_level[1] = 1'b1;
        tick(14);
        check_value("t5_busy_pre",  btn_busy[1], 1);
        check_value("t5_valid_pre", evt_valid,   1);
        reset_n = 1'b0;
        #1;
        check_value("t5_valid_rst", evt_valid, 0);
        check_value("t5_busy_rst",  btn_busy,  0);
        tick(1);
        reset_n = 1'b1;
        clear_log();
        evt_ready = 1'b1;
        tick(8);
        check_value("t5_count", q_btn.size(), 1);
        check_evt("t5_e0", 0, 1, c_press);
        check_value("t5_busy_post", btn_busy[1], 1);
        btn_level = '0;
        tick(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
